mult_sequencial: RTL and testbench

//   Multi-cycle shift-add multiplier for the RV64M MUL/MULH/MULHSU/MULHU group.

---
 rtl/mult_sequencial.sv | 106 ++++++++++
 tb/tb_mult_sequencial.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencial.sv
// Sequential shift-add multiplier for the RV64M MUL/MULH/MULHSU/MULHU group.
// Magnitudes are multiplied one multiplier bit per cycle; the sign is applied once at the end.
module mult_sequencial #(
    parameter int BITS = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic [BITS-1:0] op_a,
    input  logic [BITS-1:0] op_b,
    input  logic            signed_a,
    input  logic            signed_b,
    input  logic            high,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] result
);
    localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q;
    logic [BITS-1:0]   mcand_q;
    logic [2*BITS-1:0] acc_q;
    logic [CW-1:0]     cnt_q;
    logic              neg_q;
    logic              high_q;
    logic              busy_q;
    logic              done_q;
    logic [BITS-1:0]   result_q;

    logic              neg_a_d;
    logic              neg_b_d;
    logic [BITS-1:0]   mag_a_d;
    logic [BITS-1:0]   mag_b_d;
    logic [BITS:0]     sum_d;
    logic [2*BITS-1:0] acc_d;
    logic [2*BITS-1:0] prod_d;

    // The most-negative operand negates to itself, which is already its unsigned magnitude.
    assign neg_a_d = signed_a & op_a[BITS-1];
    assign neg_b_d = signed_b & op_b[BITS-1];
    assign mag_a_d = neg_a_d ? (~op_a + 1'b1) : op_a;
    assign mag_b_d = neg_b_d ? (~op_b + 1'b1) : op_b;

    // Multiplier occupies the low accumulator half and is consumed as the partial product shifts in.
    assign sum_d  = {1'b0, acc_q[2*BITS-1:BITS]} + {1'b0, (acc_q[0] ? mcand_q : {BITS{1'b0}})};
    assign acc_d  = {sum_d, acc_q[BITS-1:1]};
    assign prod_d = neg_q ? (~acc_d + 1'b1) : acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            high_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (kill) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= BUSY;
                        busy_q  <= 1'b1;
                        mcand_q <= mag_a_d;
                        acc_q   <= {{BITS{1'b0}}, mag_b_d};
                        cnt_q   <= '0;
                        neg_q   <= neg_a_d ^ neg_b_d;
                        high_q  <= high;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(BITS - 1)) begin
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= high_q ? prod_d[2*BITS-1:BITS] : prod_d[BITS-1:0];
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mult_sequencial.sv
// Bench for mult_sequencial: directed vector table, random operands against a
// wide-integer reference product, and hand-written restart/kill/reset sequences.
module tb_mult_sequencial;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic        signed_a = 1'b0;
    logic        signed_b = 1'b0;
    logic        high = 1'b0;
    logic [63:0] op_a = '0;
    logic [63:0] op_b = '0;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sa;
        logic        sb;
        logic        h;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[9];

    mult_sequencial #(.BITS(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .kill(kill),
        .op_a(op_a), .op_b(op_b), .signed_a(signed_a), .signed_b(signed_b),
        .high(high), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Reference: full-precision integer product of the operands as interpreted by their flags.
    function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic sa, input logic sb, input logic h);
        logic signed [129:0] x;
        logic signed [129:0] y;
        logic signed [129:0] p;
        x = sa ? {{66{a[63]}}, a} : {66'b0, a};
        y = sb ? {{66{b[63]}}, b} : {66'b0, b};
        p = x * y;
        return h ? p[127:64] : p[63:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
        end
    endtask

    task automatic launch(input logic [63:0] a, input logic [63:0] b,
                          input logic sa, input logic sb, input logic h);
        op_a = a; op_b = b; signed_a = sa; signed_b = sb; high = h;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called 1 time unit after the accepting edge; lat counts that edge as 1.
    task automatic wait_done(output logic [63:0] res, output int lat, output int bcnt);
        res = '0; lat = 1; bcnt = 0;
        for (int k = 0; k < 200; k++) begin
            if (busy) bcnt++;
            if (done) begin
                res = result;
                chk("busy_done_exclusive", {63'b0, busy}, 64'd0);
                return;
            end
            @(posedge clk); #1;
            lat++;
        end
        n_chk++;
        n_fail++;
        $display("FAIL done_timeout: no done within 200 cycles");
    endtask

    task automatic watch_no_done(input int cycles, output int seen);
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
    endtask

    initial begin
        logic [63:0] res;
        logic [63:0] a, b;
        logic        sa, sb, h;
        int          lat, bc, seen;

        tbl[0] = '{64'd6, 64'd7, 1'b0, 1'b0, 1'b0, 64'd42};
        tbl[1] = '{-64'sd3, 64'd5, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF1};
        tbl[2] = '{-64'sd3, 64'd5, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE};
        tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 64'h1};
        tbl[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b1, 64'h4000_0000_0000_0000};
        tbl[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0, 64'h0};
        tbl[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[8] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000};

        #3;
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_done", {63'b0, done}, 64'd0);
        chk("reset_result", result, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        watch_no_done(3, seen);
        chk("idle_no_done", 64'(seen), 64'd0);

        for (int i = 0; i < 9; i++) begin
            launch(tbl[i].a, tbl[i].b, tbl[i].sa, tbl[i].sb, tbl[i].h);
            wait_done(res, lat, bc);
            chk($sformatf("vec%0d_result", i), res, tbl[i].exp);
            if (i == 0) begin
                chk("latency", 64'(lat), 64'd65);
                chk("busy_cycles", 64'(bc), 64'd64);
            end
            @(posedge clk); #1;
            chk($sformatf("vec%0d_done_pulse", i), {63'b0, done}, 64'd0);
            chk($sformatf("vec%0d_result_held", i), result, tbl[i].exp);
        end

        for (int i = 0; i < 20; i++) begin
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            if (i % 5 == 1) a = 64'h8000_0000_0000_0000;
            if (i % 7 == 2) b = '1;
            sa = 1'($urandom);
            sb = 1'($urandom);
            h  = 1'($urandom);
            launch(a, b, sa, sb, h);
            wait_done(res, lat, bc);
            chk($sformatf("rand%0d", i), res, model(a, b, sa, sb, h));
            chk($sformatf("rand%0d_latency", i), 64'(lat), 64'd65);
        end

        // start during BUSY is dropped; start in the DONE cycle is accepted back-to-back
        @(posedge clk); #1;
        launch(64'd6, 64'd7, 1'b0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        op_a = 64'd9; op_b = 64'd9; high = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(res, lat, bc);
        chk("start_in_busy_ignored", res, 64'd42);
        launch(64'd3, 64'd4, 1'b0, 1'b0, 1'b0);
        wait_done(res, lat, bc);
        chk("back_to_back_result", res, 64'd12);
        chk("back_to_back_latency", 64'(lat), 64'd65);

        // kill mid-BUSY: no done, previous result stays
        @(posedge clk); #1;
        launch(64'd5, 64'd5, 1'b0, 1'b0, 1'b0);
        repeat (19) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_busy_low", {63'b0, busy}, 64'd0);
        watch_no_done(80, seen);
        chk("kill_no_done", 64'(seen), 64'd0);
        chk("kill_result_kept", result, 64'd12);

        // kill beats a simultaneous start in the DONE cycle
        launch(64'd2, 64'd3, 1'b0, 1'b0, 1'b0);
        wait_done(res, lat, bc);
        chk("pre_kill_done_result", res, 64'd6);
        op_a = 64'd100; op_b = 64'd100; start = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        chk("kill_in_done_busy", {63'b0, busy}, 64'd0);
        watch_no_done(70, seen);
        chk("kill_in_done_no_done", 64'(seen), 64'd0);
        chk("kill_in_done_result", result, 64'd6);

        // asynchronous reset mid-BUSY
        launch(64'd7, 64'd7, 1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {63'b0, busy}, 64'd0);
        chk("async_rst_done", {63'b0, done}, 64'd0);
        chk("async_rst_result", result, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        launch(64'd11, 64'd11, 1'b0, 1'b0, 1'b0);
        wait_done(res, lat, bc);
        chk("after_reset_result", res, 64'd121);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
